// File: rtl/serv_pkg.sv
// Shared opcode constants and immediate-format encoding for the SERV decoders.
package serv_pkg;

  // opcode[6:2] values of the RV32I/Zicsr major opcodes
  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_OPIMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd5
  } fmt_e;

endpackage

// File: rtl/serv_imm_assemble.sv
// Combinational immediate assembly: instruction word to format and full
// sign-extended 32-bit immediate. Bits [1:0] only matter for legality, so
// they are not brought in here.
module serv_imm_assemble
  import serv_pkg::*;
(
  input  logic [31:2] i_insn,
  output fmt_e        o_fmt,
  output logic [31:0] o_imm
);

  logic [4:0] opcode;
  assign opcode = i_insn[6:2];

  // Select the format from the major opcode and splice the immediate fields
  always_comb begin
    o_fmt = FMT_NONE;
    o_imm = 32'h0;
    case (opcode)
      OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM: begin
        o_fmt = FMT_I;
        o_imm = {{21{i_insn[31]}}, i_insn[30:20]};
      end
      OP_STORE: begin
        o_fmt = FMT_S;
        o_imm = {{21{i_insn[31]}}, i_insn[30:25], i_insn[11:7]};
      end
      OP_BRANCH: begin
        o_fmt = FMT_B;
        o_imm = {{20{i_insn[31]}}, i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
      end
      OP_AUIPC, OP_LUI: begin
        o_fmt = FMT_U;
        o_imm = {i_insn[31:12], 12'h000};
      end
      OP_JAL: begin
        o_fmt = FMT_J;
        o_imm = {{12{i_insn[31]}}, i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
      end
      default: begin
        o_fmt = FMT_NONE;
        o_imm = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/serv_immdec_w.sv
// W-bit-per-cycle immediate and zimm streamer with legality check.
// The immediate is captured whole on a load and then shifted out LSB-first;
// the sign bit is kept separately so the shift can refill with it forever.
module serv_immdec_w
  import serv_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_wb_en,
  input  logic [31:0]  i_wb_rdt,
  input  logic         i_cnt_en,
  output logic [W-1:0] o_imm,
  output logic [W-1:0] o_csr_imm,
  output logic         o_cnt_last,
  output logic         o_valid,
  output logic         o_illegal
);

  localparam int CHUNKS = 32 / W;
  localparam int CNT_W  = $clog2(CHUNKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHUNKS - 1);

  fmt_e        asm_fmt;
  logic [31:0] asm_imm;

  logic [31:0]      imm_q, imm_d;
  logic             sign_q, sign_d;
  logic [31:0]      zimm_q, zimm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;

  serv_imm_assemble u_assemble (
    .i_insn (i_wb_rdt[31:2]),
    .o_fmt  (asm_fmt),
    .o_imm  (asm_imm)
  );

  // Opcodes with no immediate format are legal only for FENCE and OP, so the
  // format result doubles as the opcode-membership test.
  function automatic logic is_illegal(input logic [31:0] rdt, input fmt_e fmt);
    logic [4:0] op;
    logic [2:0] f3;
    logic       ill;
    op  = rdt[6:2];
    f3  = rdt[14:12];
    ill = 1'b0;
    case (op)
      OP_LOAD:   ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OP_STORE:  ill = (f3 >= 3'b011);
      OP_BRANCH: ill = (f3 == 3'b010) || (f3 == 3'b011);
      OP_JALR:   ill = (f3 != 3'b000);
      OP_SYSTEM: ill = (f3 == 3'b100);
      default:   ill = (fmt == FMT_NONE) && !((op == OP_MISC_MEM) || (op == OP_OP));
    endcase
    if (rdt[1:0] != 2'b11) ill = 1'b1;
    return ill;
  endfunction

  // Next state: load beats advance; advance shifts both fields and saturates the counter
  always_comb begin
    imm_d     = imm_q;
    sign_d    = sign_q;
    zimm_d    = zimm_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (i_wb_en) begin
      imm_d     = asm_imm;
      sign_d    = asm_imm[31];
      zimm_d    = {27'h0, i_wb_rdt[19:15]};
      cnt_d     = '0;
      valid_d   = 1'b1;
      illegal_d = is_illegal(i_wb_rdt, asm_fmt);
    end else if (i_cnt_en) begin
      imm_d  = {{W{sign_q}}, imm_q[31:W]};
      zimm_d = {{W{1'b0}}, zimm_q[31:W]};
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (i_rst) begin
      imm_q     <= 32'h0;
      sign_q    <= 1'b0;
      zimm_q    <= 32'h0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      imm_q     <= imm_d;
      sign_q    <= sign_d;
      zimm_q    <= zimm_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_imm      = imm_q[W-1:0];
  assign o_csr_imm  = zimm_q[W-1:0];
  assign o_cnt_last = (cnt_q == CNT_MAX);
  assign o_valid    = valid_q;
  assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_serv_immdec_w.sv
// Drives one shared stimulus into four instances (W = 1, 2, 4, 8) and checks
// every output against an arithmetic model of the immediate stream.
module tb_serv_immdec_w;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_wb_en = 1'b0;
  logic [31:0] i_wb_rdt = 32'h0;
  logic        i_cnt_en = 1'b0;

  logic [0:0] imm_1, csr_1;
  logic [1:0] imm_2, csr_2;
  logic [3:0] imm_4, csr_4;
  logic [7:0] imm_8, csr_8;
  logic [3:0] last, valid, illegal;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [31:0] m_imm = 32'h0;
  logic [31:0] m_zimm = 32'h0;
  int          m_k = 0;
  logic        m_valid = 1'b0;
  logic        m_illegal = 1'b0;

  always #5 clk = ~clk;

  serv_immdec_w #(.W(1)) u_w1 (.clk(clk), .i_rst(i_rst), .i_wb_en(i_wb_en), .i_wb_rdt(i_wb_rdt),
    .i_cnt_en(i_cnt_en), .o_imm(imm_1), .o_csr_imm(csr_1), .o_cnt_last(last[0]),
    .o_valid(valid[0]), .o_illegal(illegal[0]));
  serv_immdec_w #(.W(2)) u_w2 (.clk(clk), .i_rst(i_rst), .i_wb_en(i_wb_en), .i_wb_rdt(i_wb_rdt),
    .i_cnt_en(i_cnt_en), .o_imm(imm_2), .o_csr_imm(csr_2), .o_cnt_last(last[1]),
    .o_valid(valid[1]), .o_illegal(illegal[1]));
  serv_immdec_w #(.W(4)) u_w4 (.clk(clk), .i_rst(i_rst), .i_wb_en(i_wb_en), .i_wb_rdt(i_wb_rdt),
    .i_cnt_en(i_cnt_en), .o_imm(imm_4), .o_csr_imm(csr_4), .o_cnt_last(last[2]),
    .o_valid(valid[2]), .o_illegal(illegal[2]));
  serv_immdec_w #(.W(8)) u_w8 (.clk(clk), .i_rst(i_rst), .i_wb_en(i_wb_en), .i_wb_rdt(i_wb_rdt),
    .i_cnt_en(i_cnt_en), .o_imm(imm_8), .o_csr_imm(csr_8), .o_cnt_last(last[3]),
    .o_valid(valid[3]), .o_illegal(illegal[3]));

  logic [7:0] act_imm [4];
  logic [7:0] act_csr [4];
  assign act_imm[0] = {7'h0, imm_1};
  assign act_imm[1] = {6'h0, imm_2};
  assign act_imm[2] = {4'h0, imm_4};
  assign act_imm[3] = imm_8;
  assign act_csr[0] = {7'h0, csr_1};
  assign act_csr[1] = {6'h0, csr_2};
  assign act_csr[2] = {4'h0, csr_4};
  assign act_csr[3] = csr_8;

  // Immediate value from the RV32I format rules, written as arithmetic on fields
  function automatic logic [31:0] ref_imm(input logic [31:0] r);
    logic signed [31:0] s;
    logic [31:0] hi;
    s  = $signed(r);
    hi = 32'(s >>> 31);
    case (r[6:2])
      5'b00000, 5'b00100, 5'b11001, 5'b11100: return 32'(s >>> 20);
      5'b01000: return (32'(s >>> 25) << 5) | 32'(r[11:7]);
      5'b11000: return (hi << 12) | (32'(r[7]) << 11) | (32'(r[30:25]) << 5) | (32'(r[11:8]) << 1);
      5'b00101, 5'b01101: return r & 32'hFFFF_F000;
      5'b11011: return (hi << 20) | (32'(r[19:12]) << 12) | (32'(r[20]) << 11) | (32'(r[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] r);
    logic [2:0] f3;
    f3 = r[14:12];
    if (r[1:0] != 2'b11) return 1'b1;
    case (r[6:2])
      5'b00000: return (f3 == 3) || (f3 == 6) || (f3 == 7);
      5'b01000: return f3 >= 3;
      5'b11000: return (f3 == 2) || (f3 == 3);
      5'b11001: return f3 != 0;
      5'b11100: return f3 == 4;
      5'b00011, 5'b00100, 5'b00101, 5'b01100, 5'b01101, 5'b11011: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] wmask(input int i);
    return 8'hFF >> (8 - (1 << i));
  endfunction

  function automatic logic [7:0] exp_imm(input int i);
    longint s;
    s = longint'($signed(m_imm));
    s = s >>> (m_k * (1 << i));
    return s[7:0] & wmask(i);
  endfunction

  function automatic logic [7:0] exp_csr(input int i);
    logic [63:0] z;
    z = {32'h0, m_zimm};
    z = z >> (m_k * (1 << i));
    return z[7:0] & wmask(i);
  endfunction

  task automatic check_all();
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      e = exp_imm(i);
      vectors++;
      assert (act_imm[i] === e) else begin
        miscompares++;
        $error("FAIL imm_w%0d got %h exp %h", 1 << i, act_imm[i], e);
      end
      e = exp_csr(i);
      vectors++;
      assert (act_csr[i] === e) else begin
        miscompares++;
        $error("FAIL csr_w%0d got %h exp %h", 1 << i, act_csr[i], e);
      end
      vectors++;
      assert (last[i] === (m_k >= (32 >> i) - 1)) else begin
        miscompares++;
        $error("FAIL last_w%0d got %b exp %b k=%0d", 1 << i, last[i], m_k >= (32 >> i) - 1, m_k);
      end
      vectors++;
      assert (valid[i] === m_valid) else begin
        miscompares++;
        $error("FAIL valid_w%0d got %b exp %b", 1 << i, valid[i], m_valid);
      end
      vectors++;
      assert (illegal[i] === m_illegal) else begin
        miscompares++;
        $error("FAIL illegal_w%0d got %b exp %b", 1 << i, illegal[i], m_illegal);
      end
    end
  endtask

  task automatic kat(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic wb, input logic [31:0] rdt, input logic cnt);
    i_rst = rst; i_wb_en = wb; i_wb_rdt = rdt; i_cnt_en = cnt;
    @(posedge clk);
    if (rst) begin
      m_imm = 0; m_zimm = 0; m_k = 0; m_valid = 0; m_illegal = 0;
    end else if (wb) begin
      m_imm = ref_imm(rdt); m_zimm = {27'h0, rdt[19:15]}; m_k = 0;
      m_valid = 1; m_illegal = ref_illegal(rdt);
    end else if (cnt) begin
      if (m_k < 64) m_k++;
    end
    #1;
    i_rst = 0; i_wb_en = 0; i_cnt_en = 0;
    check_all();
  endtask

  logic [3:0]  lui_exp [9] = '{4'h0, 4'h0, 4'h0, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
  logic [1:0]  csr_exp [5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
  logic [4:0]  ops [11] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};

  initial begin
    logic [31:0] r;
    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // W=1 addi x1,x0,-1: all ones forever, last after 31 advances
    step(0, 1, 32'hFFF0_0093, 0);
    kat("addi_illegal", {7'h0, illegal[0]}, 8'h0);
    for (int i = 0; i < 34; i++) begin
      step(0, 0, 0, 1);
      if (i == 30) kat("addi_last_at_31", {7'h0, last[0]}, 8'h1);
    end
    kat("addi_sat_imm", {7'h0, imm_1}, 8'h1);

    // W=4 lui x5,0x12345
    step(0, 1, 32'h1234_52B7, 0);
    for (int i = 0; i < 9; i++) begin
      kat("lui_w4_chunk", {4'h0, imm_4}, {4'h0, lui_exp[i]});
      step(0, 0, 0, 1);
    end

    // W=8 beq -4, then load+advance together: the load wins
    step(0, 1, 32'hFE00_0EE3, 0);
    kat("beq_w8_c0", imm_8, 8'hFC);
    step(0, 0, 0, 1);
    kat("beq_w8_c1", imm_8, 8'hFF);
    step(0, 1, 32'h340A_D073, 1);
    kat("collide_w8_c0", imm_8, 8'h40);
    kat("csr_illegal", {7'h0, illegal[1]}, 8'h0);
    for (int i = 0; i < 5; i++) begin
      kat("csr_w2_chunk", {6'h0, csr_2}, {6'h0, csr_exp[i]});
      step(0, 0, 0, 1);
    end

    // legality directed cases
    step(0, 1, 32'h0000_0000, 0);
    kat("ill_zero", {7'h0, illegal[3]}, 8'h1);
    step(0, 1, 32'h0000_2067, 0);
    kat("ill_jalr_f3", {7'h0, illegal[3]}, 8'h1);
    step(0, 1, 32'h0000_000F, 0);
    kat("ill_fence", {7'h0, illegal[3]}, 8'h0);

    // reset mid-stream
    step(0, 1, 32'hFFF0_0093, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    kat("rst_valid", {4'h0, valid}, 8'h0);
    kat("rst_imm_w8", imm_8, 8'h0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    kat("rst_valid_hold", {4'h0, valid}, 8'h0);
    step(0, 1, 32'h0000_0013, 0);
    kat("reload_valid", {4'h0, valid}, 8'hF);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[6:0] = {ops[$urandom_range(0, 10)], 2'b11};
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, r, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
